// File: rtl/ifid_pipe_buffer.sv
// IF/ID elastic buffer: DEPTH-entry FIFO that stores each fetched instruction pre-decoded (R/JAL/I).
// Optional macro IFID_BUBBLE_CNT_EN adds a saturating bubble_cnt output.
module ifid_pipe_buffer #(
  parameter int PC_W    = 9,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic [PC_W-1:0]              if_pc,
  input  logic [INSTR_W-1:0]           if_instr,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [INSTR_W-1:0]           id_instr,
  output logic [PC_W-1:0]              id_pc,
  output logic [1:0]                   id_fmt,
  output logic [5:0]                   id_opcode,
  output logic [4:0]                   id_rs,
  output logic [4:0]                   id_rt,
  output logic [4:0]                   id_rd,
  output logic [15:0]                  id_imm16,
  output logic [25:0]                  id_addr26,
`ifdef IFID_BUBBLE_CNT_EN
  output logic [15:0]                  bubble_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [1:0]         fmt;
    logic [5:0]         opcode;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [15:0]        imm16;
    logic [25:0]        addr26;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_enq;
  logic             w_deq;
  entry_t           w_head;

  // Fields not used by the format stay zero so decode never sees stale bits.
  function automatic entry_t f_decode(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] instr);
    entry_t e;
    e        = '0;
    e.pc     = pc;
    e.instr  = instr;
    e.opcode = instr[31:26];
    case (instr[31:26])
      6'd0: begin
        e.fmt = 2'd0;
        e.rs  = instr[25:21];
        e.rt  = instr[20:16];
        e.rd  = instr[15:11];
      end
      6'd3: begin
        e.fmt    = 2'd1;
        e.addr26 = instr[25:0];
      end
      default: begin
        e.fmt   = 2'd2;
        e.rs    = instr[25:21];
        e.rt    = instr[20:16];
        e.imm16 = instr[15:0];
      end
    endcase
    return e;
  endfunction

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign id_valid = (r_cnt != '0);
  assign if_ready = reset & (r_cnt < CNT_W'(DEPTH));
  assign w_enq    = if_valid & if_ready & ~flush;
  assign w_deq    = id_valid & id_ready & ~flush;
  assign count    = r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= f_decode(if_pc, if_instr);
        r_wr_ptr        <= f_next(r_wr_ptr);
      end
      if (w_deq) r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Head entry is registered; empty buffer forces every id_* to zero.
  assign w_head    = id_valid ? r_mem[r_rd_ptr] : '0;
  assign id_instr  = w_head.instr;
  assign id_pc     = w_head.pc;
  assign id_fmt    = w_head.fmt;
  assign id_opcode = w_head.opcode;
  assign id_rs     = w_head.rs;
  assign id_rt     = w_head.rt;
  assign id_rd     = w_head.rd;
  assign id_imm16  = w_head.imm16;
  assign id_addr26 = w_head.addr26;

`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;

  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset)                    r_bubble_cnt <= '0;
    else if (flush)                r_bubble_cnt <= '0;
    else if (id_ready & ~id_valid) r_bubble_cnt <= f_sat_inc(r_bubble_cnt);
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_ifid_pipe_buffer.sv
// Self-checking bench for ifid_pipe_buffer (DEPTH = 3) against a queue-based reference model.
module tb_ifid_pipe_buffer;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int VW    = 1 + 9 + 32 + 2 + 6 + 15 + 16 + 26 + CW + 1;

  logic        clk = 1'b0;
  logic        reset, flush, if_valid, if_ready, id_valid, id_ready;
  logic [8:0]  if_pc, id_pc;
  logic [31:0] if_instr, id_instr;
  logic [1:0]  id_fmt;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;
  logic [25:0] id_addr26;
  logic [CW-1:0] count;
`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
  int          exp_bub;
`endif

  typedef struct packed {
    logic [8:0]  pc;
    logic [31:0] instr;
  } pkt_t;

  pkt_t mq[$];
  int   total = 0;
  int   bad   = 0;
  logic last_enq;
  logic [VW-1:0] exp_vec;

  always #5 clk = ~clk;

  ifid_pipe_buffer #(.PC_W(9), .INSTR_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_fmt(id_fmt), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_imm16(id_imm16), .id_addr26(id_addr26),
`ifdef IFID_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .count(count)
  );

  function automatic logic [VW-1:0] obs();
    return {id_valid, id_pc, id_instr, id_fmt, id_opcode, id_rs, id_rt, id_rd,
            id_imm16, id_addr26, count, if_ready};
  endfunction

  // Expected outputs straight from the field rules applied to the queue head.
  function automatic logic [VW-1:0] model_vec();
    logic [8:0]  pc  = '0;
    logic [31:0] ins = '0;
    logic [1:0]  fmt = '0;
    logic [5:0]  opc = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [15:0] imm = '0;
    logic [25:0] adr = '0;
    if (mq.size() > 0) begin
      pc  = mq[0].pc;
      ins = mq[0].instr;
      opc = ins[31:26];
      if (opc == 6'd0) begin
        fmt = 2'd0; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      end else if (opc == 6'd3) begin
        fmt = 2'd1; adr = ins[25:0];
      end else begin
        fmt = 2'd2; rs = ins[25:21]; rt = ins[20:16]; imm = ins[15:0];
      end
    end
    return {mq.size() != 0, pc, ins, fmt, opc, rs, rt, rd, imm, adr,
            CW'(mq.size()), reset && (mq.size() < DEPTH)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       r[31:26] = 6'd0;
      1:       r[31:26] = 6'd3;
      default: r[31:26] = 6'($urandom_range(1, 63));
    endcase
    return r;
  endfunction

  // Drive inputs just after a falling edge and refresh the expected output vector.
  task automatic drive(input logic r, input logic f, input logic v, input logic rdy,
                       input logic [8:0] pc, input logic [31:0] ins);
    reset = r; flush = f; if_valid = v; id_ready = rdy; if_pc = pc; if_instr = ins;
    #1;
    exp_vec = model_vec();
  endtask

  task automatic tick();
    logic en, de;
    en = reset && !flush && if_valid && (mq.size() < DEPTH);
    de = reset && !flush && id_ready && (mq.size() != 0);
`ifdef IFID_BUBBLE_CNT_EN
    if (!reset || flush) exp_bub = 0;
    else if (id_ready && mq.size() == 0 && exp_bub < 65535) exp_bub++;
`endif
    @(posedge clk);
    if (!reset || flush) mq.delete();
    else begin
      if (de) void'(mq.pop_front());
      if (en) mq.push_back('{pc: if_pc, instr: if_instr});
    end
    last_enq = en;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 0, 1, 1, 9'h1FF, 32'hFFFF_FFFF); tick();
    drive(0, 0, 1, 1, 9'h1FF, 32'hFFFF_FFFF); tick();
    drive(0, 0, 1, 1, 9'h1FF, 32'hFFFF_FFFF);
    total++;
    if (obs() !== exp_vec) begin
      bad++; $display("FAIL reset_vec got=%h exp=%h", obs(), exp_vec);
    end
    total++;
    if ({id_valid, count, if_ready} !== {1'b0, CW'(0), 1'b0}) begin
      bad++; $display("FAIL reset_ctrl got=%b%b%b exp=0/0/0", id_valid, count, if_ready);
    end
  endtask

  task automatic test_r_instr();
    drive(1, 0, 1, 0, 9'h004, 32'h012A4020);
    total++;
    if (if_ready !== 1'b1) begin
      bad++; $display("FAIL first_ready got=%b exp=1", if_ready);
    end
    tick();
    drive(1, 0, 0, 0, 9'h000, 32'h0);
    total++;
    if ({id_valid, id_fmt, id_rs, id_rt, id_rd, id_imm16, id_addr26, id_pc} !==
        {1'b1, 2'd0, 5'd9, 5'd10, 5'd8, 16'd0, 26'd0, 9'h004}) begin
      bad++; $display("FAIL r_fields got v=%b fmt=%0d rs=%0d rt=%0d rd=%0d imm=%h addr=%h pc=%h exp 1/0/9/10/8/0/0/004",
                      id_valid, id_fmt, id_rs, id_rt, id_rd, id_imm16, id_addr26, id_pc);
    end
    total++;
    if (obs() !== exp_vec) begin
      bad++; $display("FAIL r_vec got=%h exp=%h", obs(), exp_vec);
    end
    drive(1, 0, 0, 1, 9'h000, 32'h0); tick();
  endtask

  task automatic test_jal_i();
    drive(1, 0, 1, 1, 9'h010, 32'h0C000010); tick();
    drive(1, 0, 1, 1, 9'h014, 32'h8D090004);
    total++;
    if ({id_fmt, id_addr26, id_rs, id_rt, id_pc} !== {2'd1, 26'h10, 5'd0, 5'd0, 9'h010}) begin
      bad++; $display("FAIL jal_fields got fmt=%0d addr=%h rs=%0d rt=%0d pc=%h exp 1/10/0/0/010",
                      id_fmt, id_addr26, id_rs, id_rt, id_pc);
    end
    tick();
    drive(1, 0, 0, 1, 9'h000, 32'h0);
    total++;
    if ({id_fmt, id_rs, id_rt, id_imm16, id_addr26, id_rd} !== {2'd2, 5'd8, 5'd9, 16'h0004, 26'd0, 5'd0}) begin
      bad++; $display("FAIL i_fields got fmt=%0d rs=%0d rt=%0d imm=%h addr=%h rd=%0d exp 2/8/9/0004/0/0",
                      id_fmt, id_rs, id_rt, id_imm16, id_addr26, id_rd);
    end
    tick();
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL jal_i_drain got=%b exp=0", id_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [DEPTH+1];
    for (int k = 0; k <= DEPTH; k++) ins[k] = rand_instr();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, 0, 1, 0, 9'(9'h040 + k), ins[k]); tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 1, 0, 9'h040 + 9'(DEPTH), ins[DEPTH]);
      total++;
      if ({if_ready, count, id_instr} !== {1'b0, CW'(DEPTH), ins[0]}) begin
        bad++; $display("FAIL bp_full got rdy=%b cnt=%0d head=%h exp 0/%0d/%h", if_ready, count, id_instr, DEPTH, ins[0]);
      end
      tick();
    end
    drive(1, 0, 1, 1, 9'h040 + 9'(DEPTH), ins[DEPTH]);
    total++;
    if (if_ready !== 1'b0) begin
      bad++; $display("FAIL bp_no_passthru got=%b exp=0", if_ready);
    end
    tick();
    for (int k = 1; k <= DEPTH; k++) begin
      if (last_enq) drive(1, 0, 0, 1, 9'h0, 32'h0);
      else          drive(1, 0, 1, 1, 9'h040 + 9'(DEPTH), ins[DEPTH]);
      total++;
      if ({id_valid, id_instr, id_pc} !== {1'b1, ins[k], 9'(9'h040 + k)}) begin
        bad++; $display("FAIL bp_order got v=%b instr=%h pc=%h exp 1/%h/%h", id_valid, id_instr, id_pc, ins[k], 9'(9'h040 + k));
      end
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL bp_vec got=%h exp=%h", obs(), exp_vec);
      end
      tick();
    end
    drive(1, 0, 0, 1, 9'h0, 32'h0); tick();
  endtask

  task automatic test_flush();
    drive(1, 0, 1, 0, 9'h100, rand_instr()); tick();
    drive(1, 0, 1, 0, 9'h104, rand_instr()); tick();
    drive(1, 1, 1, 1, 9'h108, 32'h0C0000AA);
    total++;
    if (count !== CW'(2)) begin
      bad++; $display("FAIL flush_pre got=%0d exp=2", count);
    end
    tick();
    drive(1, 0, 0, 0, 9'h0, 32'h0);
    total++;
    if (obs() !== {{(VW-1){1'b0}}, 1'b1}) begin
      bad++; $display("FAIL flush_clear got=%h exp=%h", obs(), {{(VW-1){1'b0}}, 1'b1});
    end
    tick();
    drive(1, 0, 1, 0, 9'h10C, 32'h20000055); tick();
    drive(1, 0, 0, 1, 9'h0, 32'h0);
    total++;
    if ({count, id_pc, id_instr} !== {CW'(1), 9'h10C, 32'h20000055}) begin
      bad++; $display("FAIL flush_restart got cnt=%0d pc=%h instr=%h exp 1/10c/20000055", count, id_pc, id_instr);
    end
    tick();
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 100; i++) begin
      drive(1, 0, 1, 1, 9'(i * 4), rand_instr());
      if (i > 0) begin
        total++;
        if ({count, id_valid, id_pc, if_ready} !== {CW'(1), 1'b1, 9'((i - 1) * 4), 1'b1}) begin
          bad++; $display("FAIL stream_%0d got cnt=%0d v=%b pc=%h rdy=%b exp 1/1/%h/1",
                          i, count, id_valid, id_pc, if_ready, 9'((i - 1) * 4));
        end
      end
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL stream_vec_%0d got=%h exp=%h", i, obs(), exp_vec);
      end
      tick();
    end
    drive(1, 0, 0, 1, 9'h0, 32'h0); tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 1, 0, 9'h0A0, rand_instr()); tick();
    drive(1, 0, 1, 0, 9'h0A4, rand_instr()); tick();
    drive(0, 0, 1, 1, 9'h0A8, rand_instr());
    total++;
    if (if_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_ready got=%b exp=0", if_ready);
    end
    tick();
    drive(1, 0, 1, 0, 9'h1AA, 32'h012A4020);
    total++;
    if ({count, id_valid, if_ready} !== {CW'(0), 1'b0, 1'b1}) begin
      bad++; $display("FAIL rstmid_empty got cnt=%0d v=%b rdy=%b exp 0/0/1", count, id_valid, if_ready);
    end
    tick();
    drive(1, 0, 0, 1, 9'h0, 32'h0);
    total++;
    if ({count, id_pc} !== {CW'(1), 9'h1AA}) begin
      bad++; $display("FAIL rstmid_first got cnt=%0d pc=%h exp 1/1aa", count, id_pc);
    end
    tick();
  endtask

  task automatic test_random();
    logic v, r, f, rs;
    logic [8:0]  pc  = '0;
    logic [31:0] ins = '0;
    v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(v && !last_enq && !flush && reset)) begin
        v   = ($urandom_range(0, 3) != 0);
        pc  = 9'($urandom);
        ins = rand_instr();
      end
      r  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 24) == 0);
      rs = ($urandom_range(0, 49) != 0);
      drive(rs, f, v, r, pc, ins);
      total++;
      if (obs() !== exp_vec) begin
        bad++; $display("FAIL rand_%0d got=%h exp=%h", i, obs(), exp_vec);
      end
`ifdef IFID_BUBBLE_CNT_EN
      total++;
      if (rs && bubble_cnt !== 16'(exp_bub)) begin
        bad++; $display("FAIL rand_bub_%0d got=%0d exp=%0d", i, bubble_cnt, exp_bub);
      end
`endif
      tick();
    end
    drive(1, 1, 0, 0, 9'h0, 32'h0); tick();
  endtask

`ifdef IFID_BUBBLE_CNT_EN
  task automatic test_bubble();
    drive(1, 1, 0, 1, 9'h0, 32'h0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 1, 9'h0, 32'h0); tick();
    end
    drive(1, 0, 0, 0, 9'h0, 32'h0);
    total++;
    if (bubble_cnt !== 16'd5) begin
      bad++; $display("FAIL bubble_five got=%0d exp=5", bubble_cnt);
    end
    drive(1, 1, 0, 1, 9'h0, 32'h0); tick();
    drive(1, 0, 0, 0, 9'h0, 32'h0);
    total++;
    if (bubble_cnt !== 16'd0) begin
      bad++; $display("FAIL bubble_flush got=%0d exp=0", bubble_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = '0; if_instr = '0; last_enq = 1'b0;
`ifdef IFID_BUBBLE_CNT_EN
    exp_bub = 0;
`endif
    @(negedge clk);
    test_reset();
    test_r_instr();
    test_jal_i();
    test_backpressure();
    test_flush();
    test_streaming();
    test_reset_mid();
    test_random();
`ifdef IFID_BUBBLE_CNT_EN
    test_bubble();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
